// File: rtl/alu4.sv
// Registered ALU: eight opcodes on two WIDTH-bit operands.
// The result and the carry, zero, negative and overflow flags are registered, giving a one-cycle latency.
module alu4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;
    logic             overflow_d, overflow_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    // Extended-width add/sub: bit WIDTH is the carry out, or the borrow for subtraction
    always_comb begin
        sum_w  = {1'b0, A} + {1'b0, B};
        diff_w = {1'b0, A} - {1'b0, B};
    end

    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (op)
            OP_ADD: begin
                result_d   = sum_w[MSB:0];
                carry_d    = sum_w[WIDTH];
                overflow_d = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
            end
            OP_SUB: begin
                result_d   = diff_w[MSB:0];
                carry_d    = diff_w[WIDTH];
                overflow_d = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
            end
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_XOR: result_d = A ^ B;
            OP_NOT: result_d = ~A;
            OP_SHL: begin
                result_d = {A[MSB-1:0], 1'b0};
                carry_d  = A[MSB];
            end
            OP_SHR: begin
                result_d = {1'b0, A[MSB:1]};
                carry_d  = A[0];
            end
            default: result_d = '0;
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[MSB];
    end

    // Reset state shows an all-zero result, so zero reads as 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu4.sv
// Testbench for alu4: directed cases, latency and reset checks, random operations and an exhaustive sweep.
// Expected values come from fixed constants or from an integer reference model of the opcode rules.
module tb_alu4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic [2:0] op;
    logic [3:0] result;
    logic       carry, zero, negative, overflow;

    int n_cmp = 0;
    int n_err = 0;

    alu4 #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .op(op),
        .result(result), .carry(carry), .zero(zero),
        .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Packed as {result, carry, zero, negative, overflow}
    localparam logic [7:0] RST_VAL = 8'b0000_0100;

    // Signed arithmetic on plain integers, reduced to the 4-bit result and its flags
    function automatic logic [7:0] model(input int a, input int b, input int o);
        int r, sa, sb, s;
        logic c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (o)
            0: begin r = a + b; c = (r > 15); r = r % 16; s = sa + sb; v = (s > 7) || (s < -8); end
            1: begin r = (a - b + 16) % 16; c = (a < b); s = sa - sb; v = (s > 7) || (s < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = (a >= 8); end
            default: begin r = a / 2; c = (a % 2 == 1); end
        endcase
        return {4'(r), c, (r == 0), (r >= 8), v};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {result, carry, zero, negative, overflow};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (A=%0d B=%0d op=%0d)", tag, obs, exp, A, B, op);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
        @(negedge clk);
        A  = a;
        B  = b;
        op = o;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o,
                       input string tag, input logic [7:0] exp);
        drive(a, b, o);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic [2:0] ro;
        logic [2:0] seq [3];
        logic [7:0] prev;

        rst = 1'b1;
        A   = 4'd5;
        B   = 4'd7;
        op  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", RST_VAL);
        @(negedge clk);
        rst = 1'b0;

        run(4'b0010, 4'b0011, 3'd0, "add_2_3", 8'b0101_0000);
        run(4'b0010, 4'b0011, 3'd1, "sub_2_3", 8'b1111_1010);
        run(4'b0010, 4'b0011, 3'd2, "and_2_3", 8'b0010_0000);
        run(4'b0010, 4'b0011, 3'd3, "or_2_3",  8'b0011_0000);
        run(4'b0010, 4'b0011, 3'd4, "xor_2_3", 8'b0001_0000);

        run(4'b0111, 4'b0001, 3'd0, "add_ovf",  8'b1000_0011);
        run(4'b1111, 4'b0001, 3'd0, "add_wrap", 8'b0000_1100);
        run(4'b1000, 4'b0001, 3'd1, "sub_ovf",  8'b0111_0001);

        run(4'b1001, 4'b0000, 3'd6, "shl_9", 8'b0010_1000);
        run(4'b1001, 4'b0000, 3'd7, "shr_9", 8'b0100_1000);
        run(4'b1001, 4'b1111, 3'd5, "not_9", 8'b0110_0000);

        // Outputs must hold the previous result until the edge that samples the new inputs
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd4;
        prev = {result, carry, zero, negative, overflow};
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 4'b0011, seq[i]);
            #1;
            check("latency_pre_edge", prev);
            @(posedge clk);
            #1;
            check("latency_post_edge", model(2, 3, int'(seq[i])));
            prev = model(2, 3, int'(seq[i]));
        end

        // Asynchronous reset between edges, held across an edge, then released
        run(4'b0010, 4'b0011, 3'd0, "pre_reset", 8'b0101_0000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", RST_VAL);
        A  = 4'b1001;
        op = 3'd6;
        @(posedge clk);
        #1;
        check("reset_over_edge", RST_VAL);
        @(negedge clk);
        rst = 1'b0;
        A   = 4'b0010;
        B   = 4'b0011;
        op  = 3'd0;
        @(posedge clk);
        #1;
        check("post_reset", 8'b0101_0000);

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ro = 3'($urandom_range(0, 7));
            run(ra, rb, ro, "random", model(int'(ra), int'(rb), int'(ro)));
        end

        for (int o = 0; o < 8; o++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run(4'(a), 4'(b), 3'(o), "sweep", model(a, b, o));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
